// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide on operand magnitudes, with sign fix-up at the end.
module ex_muldiv_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned REGADDR_LEN = 5
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_i,
  input  logic                   start_i,
  input  logic [2:0]             funct3_i,
  input  logic [XLEN-1:0]        rs1_data_i,
  input  logic [XLEN-1:0]        rs2_data_i,
  input  logic [REGADDR_LEN-1:0] rd_addr_i,
  output logic                   stall_req_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [XLEN-1:0]        rd_data_o,
  output logic [REGADDR_LEN-1:0] rd_addr_o,
  output logic                   rd_write_enable_o
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [1:0]             funct3_q, funct3_d;
  logic [REGADDR_LEN-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]        opb_q, opb_d;
  logic [2*XLEN-1:0]      acc_q, acc_d;
  logic                   neg_q, neg_d;
  logic                   a_neg_q, a_neg_d;
  logic [XLEN-1:0]        rd_data_q, rd_data_d;

  // Operand decode at accept
  logic            a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    a_signed = funct3_i[2] ? !funct3_i[0] : (funct3_i[1:0] == 2'b01 || funct3_i[1:0] == 2'b10);
    b_signed = funct3_i[2] ? !funct3_i[0] : (funct3_i[1:0] == 2'b01);
    a_neg    = a_signed && rs1_data_i[XLEN-1];
    b_neg    = b_signed && rs2_data_i[XLEN-1];
    a_mag    = a_neg ? -rs1_data_i : rs1_data_i;
    b_mag    = b_neg ? -rs2_data_i : rs2_data_i;
    div_zero = (rs2_data_i == '0);
    div_ovf  = !funct3_i[0] && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_data_i);
    special  = funct3_i[2] && (div_zero || div_ovf);
    if (div_zero) special_res = funct3_i[1] ? rs1_data_i : '1;
    else          special_res = funct3_i[1] ? '0 : rs1_data_i;
  end

  // One iteration step; multiplier/quotient bits live in the low half of acc_q
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, step_acc, prod_s;
  logic [XLEN-1:0]   quo, rem, mul_res, div_res, fin_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : {XLEN{1'b0}})};
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opb_q};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step_acc  = (state_q == StDiv) ? div_next : mul_next;

    prod_s  = neg_q ? -step_acc : step_acc;
    mul_res = (funct3_q == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    quo     = step_acc[XLEN-1:0];
    rem     = step_acc[2*XLEN-1:XLEN];
    div_res = funct3_q[1] ? (a_neg_q ? -rem : rem) : (neg_q ? -quo : quo);
    fin_res = (state_q == StDiv) ? div_res : mul_res;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    funct3_d  = funct3_q;
    rd_addr_d = rd_addr_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    a_neg_d   = a_neg_q;
    rd_data_d = rd_data_q;
    if (flush_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            cnt_d     = '0;
            funct3_d  = funct3_i[1:0];
            rd_addr_d = rd_addr_i;
            neg_d     = a_neg ^ b_neg;
            a_neg_d   = a_neg;
            opb_d     = funct3_i[2] ? b_mag : a_mag;
            acc_d     = {{XLEN{1'b0}}, (funct3_i[2] ? a_mag : b_mag)};
            if (special) begin
              state_d   = StDone;
              rd_data_d = special_res;
            end else begin
              state_d = funct3_i[2] ? StDiv : StMul;
            end
          end
        end
        StMul, StDiv: begin
          acc_d = step_acc;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_d   = StDone;
            rd_data_d = fin_res;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      funct3_q  <= '0;
      rd_addr_q <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      a_neg_q   <= 1'b0;
      rd_data_q <= '0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      funct3_q  <= funct3_d;
      rd_addr_q <= rd_addr_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      a_neg_q   <= a_neg_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign busy_o            = (state_q != StIdle);
  assign done_o            = (state_q == StDone);
  assign rd_data_o         = rd_data_q;
  assign rd_addr_o         = rd_addr_q;
  assign rd_write_enable_o = done_o && (rd_addr_q != '0);
  assign stall_req_o       = ((state_q == StIdle) && start_i && !flush_i) ||
                             (state_q == StMul) || (state_q == StDiv);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: vector table with scoreboard, plus flush/reset/ready sequences.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        stall_req, busy, done, we;
  logic [31:0] rd_data;
  logic [4:0]  rd_addr;

  logic        start64;
  logic [2:0]  funct3_64;
  logic [63:0] rs1_64, rs2_64;
  logic [4:0]  rd64;
  logic        stall64, busy64, done64, we64;
  logic [63:0] rd_data64;
  logic [4:0]  rd_addr64;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .REGADDR_LEN(5)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_i(flush), .start_i(start),
    .funct3_i(funct3), .rs1_data_i(rs1), .rs2_data_i(rs2), .rd_addr_i(rd),
    .stall_req_o(stall_req), .busy_o(busy), .done_o(done), .rd_data_o(rd_data),
    .rd_addr_o(rd_addr), .rd_write_enable_o(we)
  );

  ex_muldiv_unit #(.XLEN(64), .REGADDR_LEN(5)) dut64 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_i(flush), .start_i(start64),
    .funct3_i(funct3_64), .rs1_data_i(rs1_64), .rs2_data_i(rs2_64), .rd_addr_i(rd64),
    .stall_req_o(stall64), .busy_o(busy64), .done_o(done64), .rd_data_o(rd_data64),
    .rd_addr_o(rd_addr64), .rd_write_enable_o(we64)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] r, input logic [31:0] e, input int l);
    vec_t v;
    v.f3 = f3; v.a = a; v.b = b; v.rd = r; v.exp = e; v.lat = l;
    return v;
  endfunction

  // Scoreboard: every done_o strobe must match the oldest pushed expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done_o=1 rd_data=%h required no result", rd_data);
      end else begin
        e = sb.pop_front();
        check("sb_data", 64'(rd_data), 64'(e.data));
        check("sb_rd", 64'(rd_addr), 64'(e.rd));
        check("sb_we", 64'(we), 64'(e.we));
      end
    end
  end

  task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] r);
    @(negedge clk);
    funct3 = f3; rs1 = a; rs2 = b; rd = r; start = 1'b1;
    #1 check("stall_on_start", 64'(stall_req), 64'd1);
    @(posedge clk);
    #1 start = 1'b0;
    rs1 = $urandom;
    rs2 = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) break;
    end
    if (done !== 1'b1) check("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   lat;
    e.data = v.exp; e.rd = v.rd; e.we = (v.rd != 5'd0);
    sb.push_back(e);
    drive_start(v.f3, v.a, v.b, v.rd);
    wait_done(lat);
    check("latency", 64'(lat), 64'(v.lat));
    check("stall_in_done", 64'(stall_req), 64'd0);
    @(posedge clk);
  endtask

  initial begin
    int   lat;
    exp_t e;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; start = 1'b0;
    funct3 = '0; rs1 = '0; rs2 = '0; rd = '0;
    start64 = 1'b0; funct3_64 = '0; rs1_64 = '0; rs2_64 = '0; rd64 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data", 64'(rd_data), 64'd0);
    check("rst_addr", 64'(rd_addr), 64'd0);
    check("rst_we", 64'(we), 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    rst = 1'b0;

    vecs.push_back(mk(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 33));
    vecs.push_back(mk(3'b001, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000, 33));
    vecs.push_back(mk(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE, 33));
    vecs.push_back(mk(3'b010, 32'hFFFFFFFF, 32'd2, 5'd8, 32'hFFFFFFFF, 33));
    vecs.push_back(mk(3'b010, 32'h80000000, 32'hFFFFFFFF, 5'd9, 32'h80000000, 33));
    vecs.push_back(mk(3'b001, 32'hFFFFFFFD, 32'd5, 5'd10, 32'hFFFFFFFF, 33));
    vecs.push_back(mk(3'b011, 32'h12345678, 32'h9ABCDEF0, 5'd11,
                      32'((64'h12345678 * 64'h9ABCDEF0) >> 32), 33));
    vecs.push_back(mk(3'b000, 32'h12345678, 32'h9ABCDEF0, 5'd12,
                      32'(64'h12345678 * 64'h9ABCDEF0), 33));
    vecs.push_back(mk(3'b000, 32'd3, 32'd4, 5'd0, 32'd12, 33));
    vecs.push_back(mk(3'b101, 32'd100, 32'd7, 5'd13, 32'd14, 33));
    vecs.push_back(mk(3'b111, 32'd100, 32'd7, 5'd14, 32'd2, 33));
    vecs.push_back(mk(3'b100, 32'hFFFFFF9C, 32'd7, 5'd15, 32'hFFFFFFF2, 33));
    vecs.push_back(mk(3'b110, 32'hFFFFFF9C, 32'd7, 5'd16, 32'hFFFFFFFE, 33));
    vecs.push_back(mk(3'b100, 32'd100, 32'hFFFFFFF9, 5'd17, 32'hFFFFFFF2, 33));
    vecs.push_back(mk(3'b110, 32'd100, 32'hFFFFFFF9, 5'd18, 32'd2, 33));
    vecs.push_back(mk(3'b110, 32'hFFFFFF9C, 32'hFFFFFFF9, 5'd19, 32'hFFFFFFFE, 33));
    vecs.push_back(mk(3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'd0, 33));
    vecs.push_back(mk(3'b111, 32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000, 33));
    vecs.push_back(mk(3'b100, 32'd1234, 32'd0, 5'd22, 32'hFFFFFFFF, 1));
    vecs.push_back(mk(3'b101, 32'd9, 32'd0, 5'd23, 32'hFFFFFFFF, 1));
    vecs.push_back(mk(3'b110, 32'd5, 32'd0, 5'd24, 32'd5, 1));
    vecs.push_back(mk(3'b111, 32'd5, 32'd0, 5'd25, 32'd5, 1));
    vecs.push_back(mk(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd26, 32'h80000000, 1));
    vecs.push_back(mk(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd27, 32'd0, 1));
    foreach (vecs[i]) run_vec(vecs[i]);

    // Flush during MUL: no result may ever appear
    drive_start(3'b000, 32'd3, 32'd5, 5'd7);
    repeat (10) @(negedge clk);
    check("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy_after", 64'(busy), 64'd0);
    check("flush_stall_after", 64'(stall_req), 64'd0);
    repeat (40) @(negedge clk);

    // Flush overrides start in the same cycle
    @(negedge clk);
    funct3 = 3'b000; rs1 = 32'd2; rs2 = 32'd2; rd = 5'd3; start = 1'b1; flush = 1'b1;
    #1 check("flush_start_stall", 64'(stall_req), 64'd0);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", 64'(busy), 64'd0);

    // Reset mid-DIV discards the op and clears outputs
    drive_start(3'b100, 32'd1000, 32'd3, 5'd9);
    repeat (5) @(negedge clk);
    check("rst_mid_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_data", 64'(rd_data), 64'd0);
    check("rst_mid_addr", 64'(rd_addr), 64'd0);
    check("rst_mid_we", 64'(we), 64'd0);
    repeat (40) @(negedge clk);

    // rdy low for 5 cycles during DIV delays done by exactly 5
    e.data = 32'd333; e.rd = 5'd10; e.we = 1'b1;
    sb.push_back(e);
    drive_start(3'b100, 32'd1000, 32'd3, 5'd10);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 8) rdy = 1'b0;
      if (lat == 10) begin
        check("rdy_freeze_busy", 64'(busy), 64'd1);
        check("rdy_freeze_stall", 64'(stall_req), 64'd1);
      end
      if (lat == 13) rdy = 1'b1;
      if (done === 1'b1) break;
    end
    check("rdy_latency", 64'(lat), 64'd38);
    @(posedge clk);

    // XLEN=64 multiply latency and result
    @(negedge clk);
    funct3_64 = 3'b000; rs1_64 = 64'd7; rs2_64 = 64'hFFFFFFFFFFFFFFFD; rd64 = 5'd4;
    start64 = 1'b1;
    @(posedge clk);
    #1 start64 = 1'b0;
    rs1_64 = 64'h0123456789ABCDEF;
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (done64 === 1'b1) break;
    end
    check("x64_latency", 64'(lat), 64'd65);
    check("x64_data", rd_data64, 64'hFFFFFFFFFFFFFFEB);
    check("x64_we", 64'(we64), 64'd1);

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
